booth_multiplier_seq: RTL and testbench

//   Multi-cycle signed radix-2 Booth multiplier for the ALU multiply path.

---
 rtl/booth_multiplier_seq.sv | 120 ++++++++++++
 tb/tb_booth_multiplier_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
//   Multi-cycle signed radix-2 Booth multiplier. One Booth step (optional
//   add/subtract of the multiplicand, then an arithmetic shift) is done per
//   clock. After WIDTH steps the low WIDTH bits of the product are
//   registered, together with an overflow flag. A one-cycle ready pulse
//   marks the result.
//
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous, active-low reset
//   ctrl_mult       start pulse; accepted in IDLE or DONE
//   data_operandA   multiplicand, two's complement
//   data_operandB   multiplier, two's complement
//   data_result     product[WIDTH-1:0], registered
//   data_exception  product does not fit in WIDTH signed bits
//   data_resultRDY  one-cycle pulse: result/exception valid
//   busy            high while a multiply is in progress
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_mult,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // P = { upper accumulator (WIDTH+1), multiplier (WIDTH), Booth guard bit }
    localparam int PW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic signed [WIDTH:0]   m_reg;
    logic signed [PW-1:0]    p_reg;
    logic        [CW-1:0]    count;

    logic                    start;
    logic                    last_step;
    logic signed [WIDTH:0]   upper;
    logic signed [WIDTH:0]   upper_sum;
    logic signed [PW-1:0]    p_step;

    // True when all bits are equal, i.e. the value collapses to one sign bit.
    function automatic logic fits_signed(input logic [WIDTH:0] hi);
        return (&hi) | ~(|hi);
    endfunction

    assign start     = (state != RUN) && ctrl_mult;
    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));
    assign busy      = (state == RUN);

    // One Booth step on the current P.
    always_comb begin
        upper = p_reg[PW-1:WIDTH+1];
        case (p_reg[1:0])
            2'b01:   upper_sum = upper + m_reg;
            2'b10:   upper_sum = upper - m_reg;
            default: upper_sum = upper;
        endcase
        p_step = $signed({upper_sum, p_reg[WIDTH:0]}) >>> 1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_mult) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = ctrl_mult ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg          <= '0;
            p_reg          <= '0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (start) begin
            m_reg          <= {data_operandA[WIDTH-1], data_operandA};
            p_reg          <= {{(WIDTH + 1){1'b0}}, data_operandB, 1'b0};
            count          <= '0;
            data_resultRDY <= 1'b0;
        end else if (state == RUN) begin
            p_reg <= p_step;
            count <= count + CW'(1);
            if (last_step) begin
                // Product sits in p_step[2W:1]; the low half is bits [W:1].
                data_result    <= p_step[WIDTH:1];
                data_exception <= ~fits_signed(p_step[2*WIDTH:WIDTH]);
                data_resultRDY <= 1'b1;
            end else begin
                data_resultRDY <= 1'b0;
            end
        end else begin
            data_resultRDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq
//   Directed bench for booth_multiplier_seq (WIDTH=32). Expected products
//   come from a reference multiply and are queued at issue time, then popped
//   when the ready pulse appears.
module tb_booth_multiplier_seq;

    localparam int W = 32;

    logic         clock;
    logic         reset_n;
    logic         ctrl_mult;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int tests;
    int fails;
    logic [W:0] exp_q[$];

    booth_multiplier_seq #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: {overflow, product[W-1:0]}
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic                  ovf;
        p   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        ovf = (p != {{W{p[W-1]}}, p[W-1:0]});
        return {ovf, p[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; the next edge is the start edge E0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_mult     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        exp_q.push_back(model(a, b));
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
    endtask

    // Waits (bounded) for the ready pulse, then checks latency and result.
    task automatic finish_op(input string tag, input int exp_lat);
        int         n;
        logic [W:0] e;
        n = 0;
        while (n < W + 8 && !data_resultRDY) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check({tag, " result"}, 64'(data_result), 64'(e[W-1:0]));
        check({tag, " exception"}, 64'(data_exception), 64'(e[W]));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        check({tag, " busy"}, 64'(busy), 64'(1));
        finish_op(tag, W);
        @(posedge clock);
        #1;
        check({tag, " rdy drop"}, 64'(data_resultRDY), 64'(0));
        check({tag, " hold"}, 64'(data_result), 64'(model(a, b) & {1'b0, {W{1'b1}}}));
    endtask

    initial begin
        int rdy_cnt;
        tests         = 0;
        fails         = 0;
        reset_n       = 1'b0;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset result", 64'(data_result), 64'(0));
        check("reset exception", 64'(data_exception), 64'(0));
        check("reset rdy", 64'(data_resultRDY), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op("3x4", 32'd3, 32'd4);
        run_op("-7x6", 32'hFFFF_FFF9, 32'd6);
        run_op("maxpos x2", 32'h7FFF_FFFF, 32'd2);
        run_op("minneg x -1", 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("minneg x1", 32'h8000_0000, 32'd1);
        run_op("minneg x minneg", 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            run_op("random", $urandom, $urandom);
        end

        // Start pulse and operand changes during RUN are ignored.
        start_op(32'd5, 32'd5);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        ctrl_mult     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        finish_op("5x5 ignore", W - 10);

        // Back-to-back issue in the DONE cycle.
        start_op(32'd9, 32'd9);
        finish_op("9x9 b2b", W);

        // Reset in the middle of an operation.
        start_op(32'd5, 32'd5);
        repeat (11) begin
            @(posedge clock);
            #1;
        end
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset result", 64'(data_result), 64'(0));
        check("midreset exception", 64'(data_exception), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        rdy_cnt = 0;
        repeat (W + 5) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        check("midreset no rdy", 64'(rdy_cnt), 64'(0));
        run_op("2x3", 32'd2, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
